// File: rtl/adc_seq_pkg.sv
// Shared types and helpers for the ADC scan sequencer: FSM state encoding,
// index-width helper and the default conversion timeout.
package adc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_START  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_STORE  = 3'd4,
      ST_NEXT   = 3'd5
   } seq_state_t;

   localparam int DEFAULT_TIMEOUT = 4096;

   // Width of an index addressing n items; never below one bit.
   function automatic int width_of(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/adc_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding {channel, result} words.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module adc_result_fifo
   import adc_seq_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointers carry one extra wrap bit so their difference is the level.
   assign level   = wr_ptr - rd_ptr;
   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Multi-channel SAR ADC scan controller: walks an enable mask, drives the mux,
// starts conversions and queues {channel, result} words into a result FIFO.
module adc_scan_sequencer
   import adc_seq_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int RESULT_W    = 16,
   parameter  int FIFO_DEPTH  = 8,
   parameter  int START_W     = 4,
   parameter  int TIMEOUT_CYC = DEFAULT_TIMEOUT,
   localparam int CH_W        = width_of(NUM_CH),
   localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     scan_start_in,
   input  logic                     scan_stop_in,
   input  logic                     mode_continuous_in,
   input  logic [NUM_CH-1:0]        ch_enable_in,
   input  logic [7:0]               settle_cycles_in,
   input  logic [RESULT_W-1:0]      adc_result_in,
   input  logic                     adc_finished_in,
   output logic                     adc_start_out,
   output logic [CH_W-1:0]          adc_ch_sel_out,
   output logic                     busy_out,
   output logic [CH_W+RESULT_W-1:0] data_out,
   output logic                     data_valid_out,
   input  logic                     data_ready_in,
   output logic [LVL_W-1:0]         fifo_level_out,
   output logic                     overflow_out,
   output logic                     timeout_out,
   input  logic                     err_clear_in,
   output logic [2:0]               dbg_state
);

   // Wide enough for the timeout count and any 8-bit settle value.
   localparam int CNT_W = width_of(TIMEOUT_CYC + 256);

   seq_state_t          state;
   seq_state_t          state_nx;
   logic [CNT_W-1:0]    cnt;
   logic [NUM_CH-1:0]   mask;
   logic                cont;
   logic                stop_pending;
   logic [CH_W-1:0]     ch;
   logic [CH_W-1:0]     ch_nx;
   logic [RESULT_W-1:0] result;
   logic                fin_s1;
   logic                fin_s2;
   logic                fin_s3;
   logic                fin_rise;
   logic                scan_latch;
   logic                ch_load;
   logic                capture;
   logic                push;
   logic                pop;
   logic                timeout_set;
   logic                ovf_set;
   logic                fifo_full;
   logic                fifo_empty;
   logic                settle_zero;
   logic [CH_W:0]       first_hit;
   logic [CH_W:0]       next_hit;
   logic [CH_W:0]       wrap_hit;

   // Returns {found, index} of the lowest enabled channel above cur,
   // or of the lowest enabled channel overall when from_lowest is set.
   function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] m,
                                             input logic [CH_W-1:0]   cur,
                                             input logic              from_lowest);
      logic [CH_W:0] r;
      r = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m[i] && (from_lowest || (i > int'(cur)))) begin
            r = {1'b1, CH_W'(i)};
         end
      end
      return r;
   endfunction

   assign first_hit   = find_ch(ch_enable_in, '0, 1'b1);
   assign next_hit    = find_ch(mask, ch, 1'b0);
   assign wrap_hit    = find_ch(mask, '0, 1'b1);
   assign settle_zero = (settle_cycles_in == 8'd0);

   // adc_finished_in is asynchronous: two-flop sync, then a registered edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         fin_s1   <= 1'b0;
         fin_s2   <= 1'b0;
         fin_s3   <= 1'b0;
         fin_rise <= 1'b0;
      end else begin
         fin_s1   <= adc_finished_in;
         fin_s2   <= fin_s1;
         fin_s3   <= fin_s2;
         fin_rise <= fin_s2 & ~fin_s3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      ch_nx       = ch;
      scan_latch  = 1'b0;
      ch_load     = 1'b0;
      capture     = 1'b0;
      push        = 1'b0;
      timeout_set = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (scan_start_in && first_hit[CH_W]) begin
               scan_latch = 1'b1;
               ch_load    = 1'b1;
               ch_nx      = first_hit[CH_W-1:0];
               state_nx   = settle_zero ? ST_START : ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if ((cnt + 1'b1) >= CNT_W'(settle_cycles_in)) begin
               state_nx = ST_START;
            end
         end
         ST_START: begin
            if (cnt == CNT_W'(START_W - 1)) begin
               state_nx = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (fin_rise) begin
               capture  = 1'b1;
               state_nx = ST_STORE;
            end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
               timeout_set = 1'b1;
               state_nx    = ST_NEXT;
            end
         end
         ST_STORE: begin
            push     = 1'b1;
            state_nx = ST_NEXT;
         end
         ST_NEXT: begin
            if (next_hit[CH_W] && !stop_pending) begin
               ch_load  = 1'b1;
               ch_nx    = next_hit[CH_W-1:0];
               state_nx = settle_zero ? ST_START : ST_SETTLE;
            end else if (next_hit[CH_W] || !cont || stop_pending) begin
               state_nx = ST_IDLE;
            end else begin
               ch_load  = 1'b1;
               ch_nx    = wrap_hit[CH_W-1:0];
               state_nx = settle_zero ? ST_START : ST_SETTLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // The phase counter restarts on every state change.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (state_nx != state) begin
         cnt <= '0;
      end else if (state != ST_IDLE) begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mask         <= '0;
         cont         <= 1'b0;
         ch           <= '0;
         result       <= '0;
         stop_pending <= 1'b0;
      end else begin
         if (scan_latch) begin
            mask <= ch_enable_in;
            cont <= mode_continuous_in;
         end
         if (ch_load) ch <= ch_nx;
         if (capture) result <= adc_result_in;
         if (state_nx == ST_IDLE) begin
            stop_pending <= 1'b0;
         end else if (scan_stop_in && state != ST_IDLE) begin
            stop_pending <= 1'b1;
         end
      end
   end

   assign pop     = data_ready_in & ~fifo_empty;
   assign ovf_set = push & fifo_full & ~pop;

   // A clear in the same cycle as a new error wins; that error is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_out <= 1'b0;
         timeout_out  <= 1'b0;
      end else begin
         overflow_out <= err_clear_in ? 1'b0 : (overflow_out | ovf_set);
         timeout_out  <= err_clear_in ? 1'b0 : (timeout_out | timeout_set);
      end
   end

   adc_result_fifo #(
      .WIDTH (CH_W + RESULT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({ch, result}),
      .pop       (data_ready_in),
      .head      (data_out),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level_out)
   );

   assign adc_start_out  = (state == ST_START);
   assign adc_ch_sel_out = ch;
   assign busy_out       = (state != ST_IDLE);
   assign data_valid_out = ~fifo_empty;
   assign dbg_state      = state;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: an ADC model answers start pulses,
// expected channel order and FIFO words are queued by each test scenario.
module tb_adc_scan_sequencer;
   import adc_seq_pkg::*;

   localparam int NUM_CH   = 4;
   localparam int RESULT_W = 16;
   localparam int START_W  = 4;
   localparam int TMO      = 64;
   localparam int ADC_LAT  = 50;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scan_start_in = 1'b0;
   logic        scan_stop_in = 1'b0;
   logic        mode_continuous_in = 1'b0;
   logic [3:0]  ch_enable_in = '0;
   logic [7:0]  settle_cycles_in = '0;
   logic [15:0] adc_result_in = '0;
   logic        adc_finished_in = 1'b0;
   logic        adc_start_out;
   logic [1:0]  adc_ch_sel_out;
   logic        busy_out;
   logic [17:0] data_out;
   logic        data_valid_out;
   logic        data_ready_in = 1'b0;
   logic [3:0]  fifo_level_out;
   logic        overflow_out;
   logic        timeout_out;
   logic        err_clear_in = 1'b0;
   logic [2:0]  dbg_state;

   adc_scan_sequencer #(
      .NUM_CH      (NUM_CH),
      .RESULT_W    (RESULT_W),
      .FIFO_DEPTH  (8),
      .START_W     (START_W),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .scan_start_in      (scan_start_in),
      .scan_stop_in       (scan_stop_in),
      .mode_continuous_in (mode_continuous_in),
      .ch_enable_in       (ch_enable_in),
      .settle_cycles_in   (settle_cycles_in),
      .adc_result_in      (adc_result_in),
      .adc_finished_in    (adc_finished_in),
      .adc_start_out      (adc_start_out),
      .adc_ch_sel_out     (adc_ch_sel_out),
      .busy_out           (busy_out),
      .data_out           (data_out),
      .data_valid_out     (data_valid_out),
      .data_ready_in      (data_ready_in),
      .fifo_level_out     (fifo_level_out),
      .overflow_out       (overflow_out),
      .timeout_out        (timeout_out),
      .err_clear_in       (err_clear_in),
      .dbg_state          (dbg_state)
   );

   // Clock / reset block
   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Scoreboard state
   int          n_cmp = 0;
   int          n_err = 0;
   logic [17:0] exp_q[$];
   logic [1:0]  exp_ch_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_conv(input int c, input bit stored);
      exp_ch_q.push_back(2'(c));
      if (stored) exp_q.push_back({2'(c), 16'h0A00 + 16'(c)});
   endtask

   // ADC model: finishes ADC_LAT cycles after a start pulse with 0x0A00+channel.
   int   start_count = 0;
   int   fin_count = 0;
   int   start_edge = 0;
   int   fin_edge = 0;
   bit   adc_no_finish = 1'b0;

   initial begin
      bit       prev_start;
      bit       pending;
      int       left;
      logic [1:0] conv_ch;
      prev_start = 1'b0;
      pending    = 1'b0;
      left       = 0;
      conv_ch    = '0;
      forever begin
         @(negedge clk);
         if (adc_start_out && !prev_start) begin
            start_count++;
            start_edge      = cyc;
            adc_finished_in = 1'b0;
            conv_ch         = adc_ch_sel_out;
            left            = ADC_LAT;
            pending         = !adc_no_finish;
         end else if (pending) begin
            left--;
            if (left == 0) begin
               adc_result_in   = 16'h0A00 + 16'(conv_ch);
               adc_finished_in = 1'b1;
               fin_count++;
               fin_edge = cyc + 1;
               pending  = 1'b0;
            end
         end
         prev_start = adc_start_out;
      end
   end

   // Compare process: start channel order, start pulse width, popped words.
   initial begin
      int hi_len;
      bit prev;
      hi_len = 0;
      prev   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hi_len = 0;
            prev   = 1'b0;
            continue;
         end
         if (adc_start_out && !prev) begin
            if (exp_ch_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL start_channel: got start on ch %0d expected no start (cycle %0d)",
                        adc_ch_sel_out, cyc);
            end else begin
               check("start_channel", adc_ch_sel_out, exp_ch_q.pop_front());
            end
         end
         if (adc_start_out) hi_len++;
         if (prev && !adc_start_out) begin
            check("start_pulse_width", hi_len, START_W);
            hi_len = 0;
         end
         prev = adc_start_out;
         if (data_valid_out && data_ready_in) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL fifo_head: got %0h expected no word (cycle %0d)", data_out, cyc);
            end else begin
               check("fifo_head", data_out, exp_q.pop_front());
            end
         end
         check("valid_vs_level", data_valid_out, fifo_level_out != 4'd0);
      end
   end

   // Driver tasks
   task automatic goto_edge(input int n);
      check("edge_schedule", cyc <= n, 1);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic step(input int n);
      goto_edge(cyc + n);
   endtask

   task automatic pulse_start();
      scan_start_in = 1'b1;
      step(1);
      scan_start_in = 1'b0;
   endtask

   task automatic wait_start(input int target);
      int n = 0;
      while (start_count < target && n < 3000) begin step(1); n++; end
      check("wait_start", start_count >= target, 1);
   endtask

   task automatic wait_fin(input int target);
      int n = 0;
      while (fin_count < target && n < 3000) begin step(1); n++; end
      check("wait_finish", fin_count >= target, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_out && n < 3000) begin step(1); n++; end
      check("wait_idle", busy_out, 0);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (data_valid_out && n < 200) begin step(1); n++; end
      check("wait_empty", fifo_level_out, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start"}, adc_start_out, 0);
      check({tag, "_ch_sel"}, adc_ch_sel_out, 0);
      check({tag, "_busy"}, busy_out, 0);
      check({tag, "_data"}, data_out, 0);
      check({tag, "_valid"}, data_valid_out, 0);
      check({tag, "_level"}, fifo_level_out, 0);
      check({tag, "_overflow"}, overflow_out, 0);
      check({tag, "_timeout"}, timeout_out, 0);
      check({tag, "_state_idle"}, dbg_state, 3'(ST_IDLE));
   endtask

   initial begin
      int base;
      int s;
      goto_edge(3);
      rst = 1'b0;
      goto_edge(4);
      check_all_zero("reset");

      // Single scan over channels 1 and 3, consumer stalled until the end.
      ch_enable_in = 4'b1010; settle_cycles_in = 8'd3; mode_continuous_in = 1'b0;
      exp_ch_q.push_back(2'd1); exp_ch_q.push_back(2'd3);
      exp_q.push_back({2'd1, 16'h0A01}); exp_q.push_back({2'd3, 16'h0A03});
      base = fin_count;
      pulse_start();
      check("busy_after_start", busy_out, 1);
      wait_fin(base + 1);
      goto_edge(fin_edge + 3);
      check("latency_not_yet_valid", data_valid_out, 0);
      goto_edge(fin_edge + 4);
      check("latency_valid", data_valid_out, 1);
      check("first_word", data_out, {2'd1, 16'h0A01});
      check("level_one", fifo_level_out, 1);
      wait_fin(base + 2);
      goto_edge(fin_edge + 4);
      check("level_two", fifo_level_out, 2);
      check("busy_after_last_store", busy_out, 1);
      goto_edge(fin_edge + 5);
      check("busy_fall", busy_out, 0);
      data_ready_in = 1'b1;
      wait_empty();
      data_ready_in = 1'b0;

      // Continuous scan of channel 0, stop requested while waiting on the ADC.
      ch_enable_in = 4'b0001; settle_cycles_in = 8'd2; mode_continuous_in = 1'b1;
      data_ready_in = 1'b1;
      exp_conv(0, 1); exp_conv(0, 1);
      base = start_count;
      pulse_start();
      wait_start(base + 2);
      step(10);
      scan_stop_in = 1'b1;
      step(1);
      scan_stop_in = 1'b0;
      check("stop_busy_in_wait", busy_out, 1);
      wait_idle();
      step(120);
      check("stop_stays_idle", busy_out, 0);
      check("stop_starts", start_count, base + 2);
      wait_empty();
      check("stop_words_drained", exp_q.size(), 0);
      data_ready_in = 1'b0;

      // Continuous 4-channel scan into a stalled FIFO: fill, overflow, push+pop at full.
      ch_enable_in = 4'b1111; settle_cycles_in = 8'd2; mode_continuous_in = 1'b1;
      for (int i = 0; i < 8; i++) exp_conv(i % 4, 1);
      exp_conv(0, 0);
      exp_conv(1, 1);
      exp_conv(2, 1);
      base = fin_count;
      pulse_start();
      wait_fin(base + 8);
      goto_edge(fin_edge + 4);
      check("full_level", fifo_level_out, 8);
      check("full_no_overflow", overflow_out, 0);
      wait_fin(base + 9);
      goto_edge(fin_edge + 3);
      check("ovf_before_9th", overflow_out, 0);
      goto_edge(fin_edge + 4);
      check("ovf_at_9th", overflow_out, 1);
      check("ovf_level_sat", fifo_level_out, 8);
      err_clear_in = 1'b1;
      step(1);
      err_clear_in = 1'b0;
      check("ovf_cleared", overflow_out, 0);
      wait_fin(base + 10);
      goto_edge(fin_edge + 3);
      data_ready_in = 1'b1;
      goto_edge(fin_edge + 4);
      check("pushpop_full_level", fifo_level_out, 8);
      check("pushpop_full_no_ovf", overflow_out, 0);
      scan_stop_in = 1'b1;
      step(1);
      scan_stop_in = 1'b0;
      wait_idle();
      wait_empty();
      check("ovf_words_drained", exp_q.size(), 0);
      check("ovf_starts_done", exp_ch_q.size(), 0);
      data_ready_in = 1'b0;

      // ADC never answers: timeouts on both channels, clear priority on the second.
      ch_enable_in = 4'b0011; settle_cycles_in = 8'd0; mode_continuous_in = 1'b0;
      adc_no_finish = 1'b1;
      exp_conv(0, 0); exp_conv(1, 0);
      base = start_count;
      pulse_start();
      wait_start(base + 1);
      s = start_edge;
      goto_edge(s + START_W + TMO - 1);
      check("timeout_before", timeout_out, 0);
      goto_edge(s + START_W + TMO);
      check("timeout_set", timeout_out, 1);
      check("timeout_no_push", data_valid_out, 0);
      err_clear_in = 1'b1;
      step(1);
      err_clear_in = 1'b0;
      check("timeout_cleared", timeout_out, 0);
      wait_start(base + 2);
      s = start_edge;
      goto_edge(s + START_W + TMO - 1);
      err_clear_in = 1'b1;
      goto_edge(s + START_W + TMO);
      err_clear_in = 1'b0;
      check("clear_beats_set", timeout_out, 0);
      goto_edge(s + START_W + TMO + 1);
      check("timeout_scan_done", busy_out, 0);
      check("timeout_fifo_empty", fifo_level_out, 0);
      adc_no_finish = 1'b0;

      // Reset in WAIT, then the ADC finishes late.
      ch_enable_in = 4'b0001; settle_cycles_in = 8'd1; mode_continuous_in = 1'b0;
      exp_conv(0, 0);
      base = start_count;
      pulse_start();
      wait_start(base + 1);
      s = start_edge;
      goto_edge(s + 10);
      rst = 1'b1;
      goto_edge(s + 12);
      check_all_zero("mid_reset");
      rst = 1'b0;
      wait_fin(fin_count + 1);
      step(12);
      check("late_fin_no_valid", data_valid_out, 0);
      check("late_fin_no_level", fifo_level_out, 0);
      check("late_fin_idle", busy_out, 0);

      // Zero-mask start is ignored; a start while busy is ignored.
      ch_enable_in = 4'b0000;
      pulse_start();
      step(3);
      check("zero_mask_idle", busy_out, 0);
      ch_enable_in = 4'b0100; settle_cycles_in = 8'd2; mode_continuous_in = 1'b0;
      data_ready_in = 1'b1;
      exp_conv(2, 1);
      base = start_count;
      pulse_start();
      wait_start(base + 1);
      step(5);
      ch_enable_in = 4'b1111; mode_continuous_in = 1'b1;
      pulse_start();
      check("busy_start_ignored", busy_out, 1);
      wait_idle();
      step(80);
      check("busy_start_one_conv", start_count, base + 1);
      wait_empty();
      check("final_words_drained", exp_q.size(), 0);
      check("final_starts_done", exp_ch_q.size(), 0);
      check("final_state_idle", dbg_state, 3'(ST_IDLE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
